// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the LEGv8 EX-stage hazard and forwarding controller.
package cpu_ctrl_pkg;
  localparam int REG_W    = 5;
  localparam int ZERO_REG = 31;

  typedef enum logic [1:0] {
    FWD_ZERO = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10,
    FWD_RF   = 2'b11
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL_LU = 2'b01,
    STALL_FL = 2'b10
  } hz_state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
    logic             setflag;
  } slot_t;

  // Observation bundle: FSM state, flag-stall countdown and the scoreboard.
  typedef struct packed {
    hz_state_t  state;
    logic [1:0] flCnt;
    slot_t      ex;
    slot_t      mem;
    slot_t      wb;
  } dbg_t;

  function automatic logic slotWrites(input slot_t s, input logic [REG_W-1:0] src);
    return s.valid && s.regwrite && (s.rd == src);
  endfunction
endpackage

// File: rtl/hazard_slot_pipe.sv
// Three-slot (EX, MEM, WB) scoreboard of in-flight destinations, plus the
// source registers of the instruction currently in EX.
module hazard_slot_pipe
  import cpu_ctrl_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_SRC = REG_W'(ZERO_REG)
)(
  input  logic             clk,
  input  logic             reset,
  input  slot_t            idSlot,
  input  logic [REG_W-1:0] idRn,
  input  logic [REG_W-1:0] idRm,
  input  logic             bubble,
  output slot_t            exSlot,
  output slot_t            memSlot,
  output slot_t            wbSlot,
  output logic [REG_W-1:0] exRn,
  output logic [REG_W-1:0] exRm
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exSlot  <= '0;
      memSlot <= '0;
      wbSlot  <= '0;
      exRn    <= RESET_SRC;
      exRm    <= RESET_SRC;
    end else begin
      wbSlot  <= memSlot;
      memSlot <= exSlot;
      // A bubble reads XZR on both ports so it never selects a forward path.
      if (bubble) begin
        exSlot <= '0;
        exRn   <= RESET_SRC;
        exRm   <= RESET_SRC;
      end else begin
        exSlot <= idSlot;
        exRn   <= idRn;
        exRm   <= idRm;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX-stage sequencing controller: operand forwarding selects, load-use and
// flag-use stalls, taken-branch flush, and saturating stall/flush counters.
module hazard_forward_ctrl #(
  parameter int REG_W      = 5,
  parameter int ZERO_REG   = 31,
  parameter int FLAG_STALL = 1,
  parameter int CNT_W      = 16
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [REG_W-1:0]   id_rn,
  input  logic [REG_W-1:0]   id_rm,
  input  logic               id_use_rn,
  input  logic               id_use_rm,
  input  logic [REG_W-1:0]   id_rd,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_setflag,
  input  logic               id_bcond,
  input  logic               id_br_taken,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               pc_we,
  output logic               ifid_we,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt,
  output cpu_ctrl_pkg::dbg_t dbg
);

  localparam logic [REG_W-1:0] ZR      = REG_W'(ZERO_REG);
  localparam logic [1:0]       FL_LOAD = 2'(FLAG_STALL - 1);

  cpu_ctrl_pkg::hz_state_t state;
  logic [1:0]              flCnt;
  cpu_ctrl_pkg::slot_t     idSlot, exSlot, memSlot, wbSlot;
  logic [REG_W-1:0]        exRn, exRm;
  logic                    luHaz, flHaz, hazRun, stalling;
  cpu_ctrl_pkg::fwd_sel_t  fwdA, fwdB;

  assign idSlot = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite,
                    memread: id_memread, setflag: id_setflag};

  hazard_slot_pipe #(.RESET_SRC(ZR)) uPipe (
    .clk     (clk),
    .reset   (reset),
    .idSlot  (idSlot),
    .idRn    (id_rn),
    .idRm    (id_rm),
    .bubble  (stalling),
    .exSlot  (exSlot),
    .memSlot (memSlot),
    .wbSlot  (wbSlot),
    .exRn    (exRn),
    .exRm    (exRm)
  );

  assign luHaz = exSlot.valid && exSlot.memread && (exSlot.rd != ZR) &&
                 ((id_use_rn && (id_rn == exSlot.rd)) ||
                  (id_use_rm && (id_rm == exSlot.rd)));
  assign flHaz    = id_bcond && exSlot.valid && exSlot.setflag;
  assign hazRun   = (state == cpu_ctrl_pkg::RUN) && (luHaz || flHaz);
  // STALL_LU is the recovery cycle after the bubble; only STALL_FL keeps holding.
  assign stalling = hazRun || (state == cpu_ctrl_pkg::STALL_FL);

  function automatic cpu_ctrl_pkg::fwd_sel_t pickFwd(input logic [REG_W-1:0] src,
                                                      input cpu_ctrl_pkg::slot_t m,
                                                      input cpu_ctrl_pkg::slot_t w);
    if (src == ZR)                            return cpu_ctrl_pkg::FWD_ZERO;
    else if (cpu_ctrl_pkg::slotWrites(m, src)) return cpu_ctrl_pkg::FWD_MEM;
    else if (cpu_ctrl_pkg::slotWrites(w, src)) return cpu_ctrl_pkg::FWD_WB;
    else                                      return cpu_ctrl_pkg::FWD_RF;
  endfunction

  assign fwdA        = pickFwd(exRn, memSlot, wbSlot);
  assign fwdB        = pickFwd(exRm, memSlot, wbSlot);
  assign fwd_a       = fwdA;
  assign fwd_b       = fwdB;
  assign pc_we       = !stalling;
  assign ifid_we     = !stalling;
  assign idex_bubble = stalling;
  assign ifid_flush  = id_br_taken && !stalling;

  // flCnt holds the stall cycles still owed after the detecting cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= cpu_ctrl_pkg::RUN;
      flCnt <= '0;
    end else begin
      case (state)
        cpu_ctrl_pkg::RUN: begin
          if (luHaz) begin
            state <= cpu_ctrl_pkg::STALL_LU;
          end else if (flHaz && (FLAG_STALL > 1)) begin
            state <= cpu_ctrl_pkg::STALL_FL;
            flCnt <= FL_LOAD;
          end
        end
        cpu_ctrl_pkg::STALL_LU: state <= cpu_ctrl_pkg::RUN;
        cpu_ctrl_pkg::STALL_FL: begin
          flCnt <= flCnt - 2'd1;
          if (flCnt <= 2'd1) state <= cpu_ctrl_pkg::RUN;
        end
        default: state <= cpu_ctrl_pkg::RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stalling && (stall_cnt != '1))   stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign dbg = '{state: state, flCnt: flCnt, ex: exSlot, mem: memSlot, wb: wbSlot};

endmodule
